axis_measure_ctrl_master: RTL and testbench

- Synthesizable AXI4-Lite initiator that drives the measurer's s_axi_control responder port.
- Replaces hand-driven register sequences with a command/response interface: clear, start, 64-bit cycle-counter read and last-frame read.
- Sits between a host-side sequencer (or on-chip self-test logic) and axis_measure_top, on the same ap_clk.

---
 rtl/axis_measure_ctrl_master.sv | 111 +++++++++++
 tb/tb_axis_measure_ctrl_master.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_measure_ctrl_master.sv
// axis_measure_ctrl_master: command-driven AXI4-Lite initiator for the measurer control port
module axis_measure_ctrl_master #(
  parameter int          ADDR_WIDTH        = 32,
  parameter logic [31:0] CONTROL_OFFSET    = 32'h00,
  parameter logic [31:0] CYCLES_OFFSET     = 32'h10,
  parameter logic [31:0] LAST_FRAME_OFFSET = 32'h20,
  parameter logic [31:0] SIG_CLEAR         = 32'h2,
  parameter logic [31:0] SIG_START         = 32'h1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [1:0]            res_op,
  output logic [63:0]           res_data,
  output logic                  res_err,
  output logic [ADDR_WIDTH-1:0] m_axi_control_awaddr,
  output logic                  m_axi_control_awvalid,
  input  logic                  m_axi_control_awready,
  output logic [31:0]           m_axi_control_wdata,
  output logic [3:0]            m_axi_control_wstrb,
  output logic                  m_axi_control_wvalid,
  input  logic                  m_axi_control_wready,
  input  logic [1:0]            m_axi_control_bresp,
  input  logic                  m_axi_control_bvalid,
  output logic                  m_axi_control_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_control_araddr,
  output logic                  m_axi_control_arvalid,
  input  logic                  m_axi_control_arready,
  input  logic [31:0]           m_axi_control_rdata,
  input  logic [1:0]            m_axi_control_rresp,
  input  logic                  m_axi_control_rvalid,
  output logic                  m_axi_control_rready
);
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESULT} state_t;
  state_t state, state_nx;
  logic [1:0] op;
  logic aw_done, w_done, beat, aw_hs, w_hs, accept;
  assign cmd_ready = state == IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign res_valid = state == RESULT;
  assign res_op = op;
  assign m_axi_control_wstrb = 4'hF;
  assign m_axi_control_awvalid = (state == WR) && !aw_done;
  assign m_axi_control_wvalid = (state == WR) && !w_done;
  assign m_axi_control_bready = state == WR_RESP;
  assign m_axi_control_arvalid = state == RD_ADDR;
  assign m_axi_control_rready = state == RD_DATA;
  assign aw_hs = m_axi_control_awvalid && m_axi_control_awready;
  assign w_hs = m_axi_control_wvalid && m_axi_control_wready;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = cmd_valid ? (cmd_op[1] ? RD_ADDR : WR) : IDLE;
      WR:      state_nx = ((aw_done || aw_hs) && (w_done || w_hs)) ? WR_RESP : WR;
      WR_RESP: state_nx = m_axi_control_bvalid ? RESULT : WR_RESP;
      RD_ADDR: state_nx = m_axi_control_arready ? RD_DATA : RD_ADDR;
      RD_DATA: state_nx = m_axi_control_rvalid ? ((op == 2'd2 && !beat) ? RD_ADDR : RESULT) : RD_DATA;
      RESULT:  state_nx = res_ready ? IDLE : RESULT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      op <= '0;
      beat <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      res_err <= 1'b0;
      res_data <= '0;
      m_axi_control_awaddr <= '0;
      m_axi_control_wdata <= '0;
      m_axi_control_araddr <= '0;
    end else begin
      if (accept) begin
        op <= cmd_op;
        beat <= 1'b0;
        aw_done <= 1'b0;
        w_done <= 1'b0;
        res_err <= 1'b0;
        res_data <= '0;
        if (cmd_op[1]) m_axi_control_araddr <= ADDR_WIDTH'(cmd_op[0] ? LAST_FRAME_OFFSET : CYCLES_OFFSET);
        else begin
          m_axi_control_awaddr <= ADDR_WIDTH'(CONTROL_OFFSET);
          m_axi_control_wdata <= cmd_op[0] ? SIG_START : SIG_CLEAR;
        end
      end
      if (state == WR) begin
        aw_done <= aw_done || aw_hs;
        w_done <= w_done || w_hs;
      end
      if (state == WR_RESP && m_axi_control_bvalid) res_err <= res_err || (m_axi_control_bresp != 2'b00);
      if (state == RD_DATA && m_axi_control_rvalid) begin
        if (beat) res_data[63:32] <= m_axi_control_rdata;
        else res_data[31:0] <= m_axi_control_rdata;
        res_err <= res_err || (m_axi_control_rresp != 2'b00);
        if (op == 2'd2 && !beat) begin
          beat <= 1'b1;
          m_axi_control_araddr <= ADDR_WIDTH'(CYCLES_OFFSET + 32'd4);
        end
      end
    end
  end
endmodule

// File: tb/tb_axis_measure_ctrl_master.sv
// tb_axis_measure_ctrl_master: directed tests against a stall-configurable AXI-Lite responder and a result model
module tb_axis_measure_ctrl_master;
  logic ap_clk = 1'b0, ap_rst_n = 1'b0;
  logic cmd_valid, cmd_ready, res_valid, res_ready, res_err;
  logic [1:0] cmd_op, res_op;
  logic [63:0] res_data;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;
  int n_pass = 0, n_chk = 0;
  int aw_stall = 0, w_stall = 0, ar_stall = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] cyc_lo = 32'd5, cyc_hi = 32'd1, lf = 32'd30;
  int aw_wait, w_wait, ar_wait;
  logic aw_seen, w_seen;
  int n_aw = 0, n_b = 0, n_ar = 0, n_awv = 0, n_wv = 0;
  logic [31:0] log_awaddr, log_wdata;
  logic [3:0] log_wstrb;
  logic [31:0] ar_log [8];
  logic m_idle;
  logic [1:0] exp_op;
  logic [63:0] exp_data;
  logic exp_err;
  logic p_aw, p_w, p_ar;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  always #5 ap_clk = ~ap_clk;
  axis_measure_ctrl_master dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .res_valid(res_valid), .res_ready(res_ready), .res_op(res_op), .res_data(res_data), .res_err(res_err),
    .m_axi_control_awaddr(awaddr), .m_axi_control_awvalid(awvalid), .m_axi_control_awready(awready),
    .m_axi_control_wdata(wdata), .m_axi_control_wstrb(wstrb), .m_axi_control_wvalid(wvalid),
    .m_axi_control_wready(wready), .m_axi_control_bresp(bresp), .m_axi_control_bvalid(bvalid),
    .m_axi_control_bready(bready), .m_axi_control_araddr(araddr), .m_axi_control_arvalid(arvalid),
    .m_axi_control_arready(arready), .m_axi_control_rdata(rdata), .m_axi_control_rresp(rresp),
    .m_axi_control_rvalid(rvalid), .m_axi_control_rready(rready)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  assign awready = awvalid && aw_wait >= aw_stall;
  assign wready = wvalid && w_wait >= w_stall;
  assign arready = arvalid && ar_wait >= ar_stall;
  assign bresp = bresp_cfg;
  assign rresp = rresp_cfg;
  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      aw_wait <= 0;
      w_wait <= 0;
      ar_wait <= 0;
      aw_seen <= 1'b0;
      w_seen <= 1'b0;
      bvalid <= 1'b0;
      rvalid <= 1'b0;
      rdata <= '0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait <= (wvalid && !wready) ? w_wait + 1 : 0;
      ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
      if (awvalid && awready) begin
        aw_seen <= 1'b1;
        log_awaddr <= awaddr;
        n_aw <= n_aw + 1;
      end
      if (wvalid && wready) begin
        w_seen <= 1'b1;
        log_wdata <= wdata;
        log_wstrb <= wstrb;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        n_b <= n_b + 1;
      end
      if ((aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready))) begin
        bvalid <= 1'b1;
        aw_seen <= 1'b0;
        w_seen <= 1'b0;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata <= araddr == 32'h10 ? cyc_lo : araddr == 32'h14 ? cyc_hi : araddr == 32'h20 ? lf : 32'hDEAD_BEEF;
        ar_log[n_ar % 8] <= araddr;
        n_ar <= n_ar + 1;
      end
    end
  end
  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) m_idle <= 1'b1;
    else if (m_idle && cmd_valid) begin
      m_idle <= 1'b0;
      exp_op <= cmd_op;
      exp_data <= cmd_op == 2'd2 ? {cyc_hi, cyc_lo} : cmd_op == 2'd3 ? {32'b0, lf} : 64'd0;
      exp_err <= cmd_op[1] ? rresp_cfg != 2'b00 : bresp_cfg != 2'b00;
    end else if (!m_idle && res_valid && res_ready) m_idle <= 1'b1;
  end
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      check("cmd_ready", cmd_ready, m_idle);
      check("res_valid_when_idle", res_valid && m_idle, 0);
      if (res_valid) begin
        check("res_op", res_op, exp_op);
        check("res_data", res_data, exp_data);
        check("res_err", res_err, exp_err);
      end
      if (wvalid) check("wstrb", wstrb, 4'hF);
      if (p_aw) check("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_w) check("w_hold", {wvalid, wdata}, {1'b1, p_wdata});
      if (p_ar) check("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
      p_aw <= awvalid && !awready;
      p_w <= wvalid && !wready;
      p_ar <= arvalid && !arready;
      p_awaddr <= awaddr;
      p_wdata <= wdata;
      p_araddr <= araddr;
      n_awv <= n_awv + int'(awvalid);
      n_wv <= n_wv + int'(wvalid);
    end else begin
      p_aw <= 1'b0;
      p_w <= 1'b0;
      p_ar <= 1'b0;
    end
  end
  task automatic do_cmd(input logic [1:0] op);
    @(negedge ap_clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    @(posedge ap_clk);
    #1 cmd_valid = 1'b0;
  endtask
  task automatic wait_res(output int lat);
    lat = -1;
    for (int i = 1; i <= 50 && lat < 0; i++) begin
      @(negedge ap_clk);
      if (res_valid) lat = i;
    end
  endtask
  task automatic finish_res();
    res_ready = 1'b1;
    @(posedge ap_clk);
    #1 res_ready = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int lat, a0, b0, v0, w0, r0;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    res_ready = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_valids", {awvalid, wvalid, bready, arvalid, rready, res_valid, res_err}, 0);
    check("rst_regs", {awaddr, wdata, araddr, res_op}, 0);
    check("rst_res_data", res_data, 0);
    @(negedge ap_clk);
    #2 ap_rst_n = 1'b1;
    do_cmd(2'd0);
    wait_res(lat);
    check("clear_latency", lat, 3);
    check("clear_awaddr", log_awaddr, 32'h0);
    check("clear_wdata", log_wdata, 32'h2);
    check("clear_wstrb", log_wstrb, 4'hF);
    check("clear_result", {res_op, res_err, res_data}, 0);
    finish_res();
    aw_stall = 2;
    a0 = n_awv;
    w0 = n_wv;
    b0 = n_b;
    do_cmd(2'd1);
    wait_res(lat);
    check("start_latency", lat, 5);
    check("start_awvalid_cycles", n_awv - a0, 3);
    check("start_wvalid_cycles", n_wv - w0, 1);
    check("start_b_count", n_b - b0, 1);
    check("start_wdata", log_wdata, 32'h1);
    check("start_res_op", res_op, 2'd1);
    finish_res();
    aw_stall = 0;
    bresp_cfg = 2'b11;
    do_cmd(2'd0);
    wait_res(lat);
    check("clear_bresp_err", res_err, 1);
    finish_res();
    bresp_cfg = 2'b00;
    r0 = n_ar;
    do_cmd(2'd2);
    wait_res(lat);
    check("cycles_latency", lat, 5);
    check("cycles_data", res_data, 64'h0000_0001_0000_0005);
    check("cycles_ar_count", n_ar - r0, 2);
    check("cycles_araddr0", ar_log[r0 % 8], 32'h10);
    check("cycles_araddr1", ar_log[(r0 + 1) % 8], 32'h14);
    finish_res();
    rresp_cfg = 2'b10;
    do_cmd(2'd3);
    wait_res(lat);
    check("lf_latency", lat, 3);
    check("lf_err_data", {res_err, res_op, res_data}, {1'b1, 2'd3, 64'h1E});
    finish_res();
    rresp_cfg = 2'b00;
    lf = 32'h1234;
    do_cmd(2'd3);
    wait_res(lat);
    a0 = n_aw;
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, 64'h1234);
      check("hold_cmd_ready", cmd_ready, 0);
      if (i == 3) begin
        cmd_valid = 1'b1;
        cmd_op = 2'd0;
      end
      if (i == 4) cmd_valid = 1'b0;
      @(negedge ap_clk);
    end
    finish_res();
    repeat (4) @(negedge ap_clk);
    check("hold_no_accept", n_aw - a0, 0);
    check("hold_idle_after", {cmd_ready, res_valid, awvalid}, 3'b100);
    ar_stall = 5;
    lf = 32'h77;
    do_cmd(2'd3);
    @(negedge ap_clk);
    check("rst_mid_arvalid_before", arvalid, 1);
    #2 ap_rst_n = 1'b0;
    #1;
    check("rst_mid_arvalid", arvalid, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    ar_stall = 0;
    lf = 32'h55;
    @(negedge ap_clk);
    #2 ap_rst_n = 1'b1;
    do_cmd(2'd3);
    wait_res(lat);
    check("post_rst_latency", lat, 3);
    check("post_rst_data", {res_err, res_data}, {1'b0, 64'h55});
    finish_res();
    repeat (2) @(negedge ap_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
